// File: rtl/clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : clock_pkg                                                   |
// | Shared BCD time types, segment codes and digit indices.              |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package clock_pkg;

   typedef logic [3:0] bcdDigit_t;

   typedef struct packed {
      bcdDigit_t hrT;
      bcdDigit_t hrU;
      bcdDigit_t minT;
      bcdDigit_t minU;
      bcdDigit_t secT;
      bcdDigit_t secU;
   } clockTime_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] DIG_MINU = 2'd0;
   localparam logic [1:0] DIG_MINT = 2'd1;
   localparam logic [1:0] DIG_HRU  = 2'd2;
   localparam logic [1:0] DIG_HRT  = 2'd3;

   localparam clockTime_t RESET_TIME_24 = 24'h00_00_00;
   localparam clockTime_t RESET_TIME_12 = 24'h12_00_00;

   function automatic logic [6:0] segDecode(input bcdDigit_t digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage
`default_nettype wire

// File: rtl/time_display_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : time_display_driver_if                                      |
// | Divider/button inputs and display/time outputs of the clock block.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface time_display_driver_if;
   logic        secondClock;
   logic        displayClock;
   logic        incMinute;
   logic        incHour;
   logic [3:0]  anode;
   logic [6:0]  segments;
   logic        dp;
   logic [23:0] bcdTime;

   modport master (
      output secondClock, displayClock, incMinute, incHour,
      input  anode, segments, dp, bcdTime
   );

   modport slave (
      input  secondClock, displayClock, incMinute, incHour,
      output anode, segments, dp, bcdTime
   );
endinterface
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : edge_sync                                                   |
// | Multi-flop synchronizer with one-cycle rising-edge tick.             |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_async,
   input  wire logic i_enable,
   output logic      o_tick
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_tick = i_enable & r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/time_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : time_display_driver                                         |
// | BCD HH:MM:SS clock with set buttons and 4-digit 7-segment mux.       |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module time_display_driver
   import clock_pkg::*;
#(
   parameter bit TWELVE_HOUR = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic            cmosClock,
   input  wire logic            reset,
   time_display_driver_if.slave bus
);

   localparam int                 c_guardW     = $clog2(SYNC_STAGES + 2);
   localparam logic [c_guardW-1:0] c_guardDone = c_guardW'(SYNC_STAGES + 1);
   localparam clockTime_t         c_resetTime  = TWELVE_HOUR ? RESET_TIME_12 : RESET_TIME_24;

   logic [c_guardW-1:0] r_guard;
   logic                w_enable;
   logic [3:0]          w_async;
   logic [3:0]          w_tick;
   logic                w_secTick;
   logic                w_minTick;
   logic                w_hourTick;
   logic                w_dispTick;

   clockTime_t          r_time;
   clockTime_t          w_next;
   logic                w_minCarry;
   logic                w_hourCarry;

   logic [1:0]          r_idx;
   logic [1:0]          w_nextIdx;
   bcdDigit_t           w_digit;
   logic                w_blank;
   logic [6:0]          w_seg;
   logic [3:0]          r_anode;
   logic [6:0]          r_seg;
   logic                r_dp;

   // Holds off ticks until the synchronizers have flushed post-reset,
   // so an input that was already high is not mistaken for an edge.
   always_ff @(posedge cmosClock) begin
      if (reset) begin
         r_guard <= '0;
      end else if (r_guard != c_guardDone) begin
         r_guard <= r_guard + 1'b1;
      end
   end

   assign w_enable = (r_guard == c_guardDone);
   assign w_async  = {bus.incHour, bus.incMinute, bus.displayClock, bus.secondClock};

   for (genvar i = 0; i < 4; i++) begin : g_sync
      edge_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_edgeSync (
         .clk      (cmosClock),
         .rst      (reset),
         .i_async  (w_async[i]),
         .i_enable (w_enable),
         .o_tick   (w_tick[i])
      );
   end

   assign w_secTick  = w_tick[0];
   assign w_dispTick = w_tick[1];
   assign w_minTick  = w_tick[2];
   assign w_hourTick = w_tick[3];

   always_comb begin
      w_next      = r_time;
      w_minCarry  = 1'b0;
      w_hourCarry = 1'b0;

      if (w_secTick) begin
         if (r_time.secU == 4'd9) begin
            w_next.secU = 4'd0;
            if (r_time.secT == 4'd5) begin
               w_next.secT = 4'd0;
               w_minCarry  = 1'b1;
            end else begin
               w_next.secT = r_time.secT + 4'd1;
            end
         end else begin
            w_next.secU = r_time.secU + 4'd1;
         end
      end

      // A button-driven 59->00 deliberately leaves the hour alone.
      if (w_minCarry || w_minTick) begin
         if (r_time.minU == 4'd9) begin
            w_next.minU = 4'd0;
            if (r_time.minT == 4'd5) begin
               w_next.minT = 4'd0;
               w_hourCarry = w_minCarry;
            end else begin
               w_next.minT = r_time.minT + 4'd1;
            end
         end else begin
            w_next.minU = r_time.minU + 4'd1;
         end
      end

      if (w_hourCarry || w_hourTick) begin
         if (TWELVE_HOUR) begin
            if (r_time.hrT == 4'd1 && r_time.hrU == 4'd2) begin
               w_next.hrT = 4'd0;
               w_next.hrU = 4'd1;
            end else if (r_time.hrU == 4'd9) begin
               w_next.hrT = r_time.hrT + 4'd1;
               w_next.hrU = 4'd0;
            end else begin
               w_next.hrU = r_time.hrU + 4'd1;
            end
         end else begin
            if (r_time.hrT == 4'd2 && r_time.hrU == 4'd3) begin
               w_next.hrT = 4'd0;
               w_next.hrU = 4'd0;
            end else if (r_time.hrU == 4'd9) begin
               w_next.hrT = r_time.hrT + 4'd1;
               w_next.hrU = 4'd0;
            end else begin
               w_next.hrU = r_time.hrU + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge cmosClock) begin
      if (reset) begin
         r_time <= c_resetTime;
      end else begin
         r_time <= w_next;
      end
   end

   assign w_nextIdx = w_dispTick ? r_idx + 2'd1 : r_idx;

   always_comb begin
      w_digit = r_time.minU;
      case (w_nextIdx)
         DIG_MINU: w_digit = r_time.minU;
         DIG_MINT: w_digit = r_time.minT;
         DIG_HRU:  w_digit = r_time.hrU;
         DIG_HRT:  w_digit = r_time.hrT;
         default:  w_digit = r_time.minU;
      endcase
   end

   assign w_blank = TWELVE_HOUR && (w_nextIdx == DIG_HRT) && (r_time.hrT == 4'd0);
   assign w_seg   = w_blank ? SEG_BLANK : segDecode(w_digit);

   always_ff @(posedge cmosClock) begin
      if (reset) begin
         r_idx   <= DIG_MINU;
         r_anode <= 4'b1110;
         r_seg   <= SEG_0;
         r_dp    <= 1'b1;
      end else begin
         r_idx   <= w_nextIdx;
         r_anode <= ~(4'b0001 << w_nextIdx);
         r_seg   <= w_seg;
         r_dp    <= ~((w_nextIdx == DIG_HRU) && !r_time.secU[0]);
      end
   end

   assign bus.anode    = r_anode;
   assign bus.segments = r_seg;
   assign bus.dp       = r_dp;
   assign bus.bcdTime  = r_time;

endmodule
`default_nettype wire

// File: tb/tb_time_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_time_display_driver                                      |
// | Scoreboard bench for 24h and 12h instances of time_display_driver.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_time_display_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst24 = 1'b0;
   logic rst12 = 1'b0;

   time_display_driver_if bus24();
   time_display_driver_if bus12();

   time_display_driver #(.TWELVE_HOUR(1'b0), .SYNC_STAGES(2)) dut24 (
      .cmosClock (clk),
      .reset     (rst24),
      .bus       (bus24.slave)
   );

   time_display_driver #(.TWELVE_HOUR(1'b1), .SYNC_STAGES(2)) dut12 (
      .cmosClock (clk),
      .reset     (rst12),
      .bus       (bus12.slave)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } dispExp_t;

   int          compared   = 0;
   int          mismatched = 0;
   int          mh, mm, ms, midx;
   bit          twelve;
   logic [23:0] expTimeQ[$];
   dispExp_t    dispQ[$];
   logic [6:0]  segTable[0:9];

   // ---------------- model ----------------
   function automatic logic [23:0] expTime();
      return {4'(mh / 10), 4'(mh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ms / 10), 4'(ms % 10)};
   endfunction

   function automatic dispExp_t expDisp();
      dispExp_t e;
      int d;
      case (midx)
         0:       begin d = mm % 10; e.an = 4'b1110; end
         1:       begin d = mm / 10; e.an = 4'b1101; end
         2:       begin d = mh % 10; e.an = 4'b1011; end
         default: begin d = mh / 10; e.an = 4'b0111; end
      endcase
      e.seg = (twelve && midx == 3 && d == 0) ? 7'h7F : segTable[d];
      e.dp  = (midx == 2 && (ms % 2) == 0) ? 1'b0 : 1'b1;
      return e;
   endfunction

   task automatic modelHour();
      if (twelve) mh = (mh == 12) ? 1 : mh + 1;
      else        mh = (mh + 1) % 24;
   endtask

   task automatic modelMin(input bit carry);
      mm++;
      if (mm == 60) begin
         mm = 0;
         if (carry) modelHour();
      end
   endtask

   task automatic modelSec();
      ms++;
      if (ms == 60) begin
         ms = 0;
         modelMin(1'b1);
      end
   endtask

   task automatic modelReset();
      mh = twelve ? 12 : 0;
      mm = 0;
      ms = 0;
      midx = 0;
   endtask

   // ---------------- DUT access ----------------
   function automatic logic [23:0] actTime();
      return twelve ? bus12.bcdTime : bus24.bcdTime;
   endfunction
   function automatic logic [3:0] actAnode();
      return twelve ? bus12.anode : bus24.anode;
   endfunction
   function automatic logic [6:0] actSeg();
      return twelve ? bus12.segments : bus24.segments;
   endfunction
   function automatic logic actDp();
      return twelve ? bus12.dp : bus24.dp;
   endfunction

   // which: 0 second, 1 minute, 2 hour, 3 display
   task automatic drive(input int which, input logic v);
      if (twelve) begin
         case (which)
            0: bus12.secondClock  = v;
            1: bus12.incMinute    = v;
            2: bus12.incHour      = v;
            default: bus12.displayClock = v;
         endcase
      end else begin
         case (which)
            0: bus24.secondClock  = v;
            1: bus24.incMinute    = v;
            2: bus24.incHour      = v;
            default: bus24.displayClock = v;
         endcase
      end
   endtask

   task automatic setRst(input logic v);
      if (twelve) rst12 = v;
      else        rst24 = v;
   endtask

   task automatic doReset();
      @(negedge clk);
      setRst(1'b1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      setRst(1'b0);
      modelReset();
   endtask

   task automatic press(input int which);
      @(negedge clk);
      drive(which, 1'b1);
      repeat (3) @(posedge clk);
      case (which)
         0: modelSec();
         1: modelMin(1'b0);
         2: modelHour();
         default: midx = (midx + 1) % 4;
      endcase
      @(negedge clk);
      drive(which, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic setTime(input int h, input int m, input int s);
      while (ms != s) press(0);
      while (mm != m) press(1);
      while (mh != h) press(2);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [23:0] e;
      doReset();
      expTimeQ.push_back(expTime());
      #1;
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL reset_time got %h want %h", actTime(), e); end
      compared++;
      if (actAnode() !== 4'b1110) begin mismatched++; $display("FAIL reset_anode got %b want 1110", actAnode()); end
      compared++;
      if (actSeg() !== 7'h40) begin mismatched++; $display("FAIL reset_seg got %h want 40", actSeg()); end
      compared++;
      if (actDp() !== 1'b1) begin mismatched++; $display("FAIL reset_dp got %b want 1", actDp()); end
      compared++;
   endtask

   task automatic test_seconds();
      logic [23:0] old, e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(0, 1'b1);
         old = expTime();
         modelSec();
         expTimeQ.push_back(expTime());
         repeat (2) @(posedge clk);
         #1;
         if (actTime() !== old) begin mismatched++; $display("FAIL sec_early[%0d] got %h want %h", i, actTime(), old); end
         compared++;
         @(posedge clk);
         #1;
         e = expTimeQ.pop_front();
         if (actTime() !== e) begin mismatched++; $display("FAIL sec_tick[%0d] got %h want %h", i, actTime(), e); end
         compared++;
         @(negedge clk);
         drive(0, 1'b0);
         repeat (3) @(negedge clk);
      end
      // Input already high across reset release must not count.
      @(negedge clk);
      drive(0, 1'b1);
      doReset();
      expTimeQ.push_back(expTime());
      repeat (8) @(posedge clk);
      #1;
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL held_high got %h want %h", actTime(), e); end
      compared++;
      @(negedge clk);
      drive(0, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_rollover();
      logic [23:0] e;
      setTime(23, 59, 58);
      expTimeQ.push_back(expTime());
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL preload got %h want %h", actTime(), e); end
      compared++;
      for (int i = 0; i < 2; i++) begin
         press(0);
         expTimeQ.push_back(expTime());
         e = expTimeQ.pop_front();
         if (actTime() !== e) begin mismatched++; $display("FAIL rollover[%0d] got %h want %h", i, actTime(), e); end
         compared++;
      end
   endtask

   task automatic test_button_no_carry();
      logic [23:0] e;
      setTime(10, 59, 30);
      press(1);
      expTimeQ.push_back(expTime());
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL min_btn_wrap got %h want %h", actTime(), e); end
      compared++;
      setTime(23, 17, 30);
      press(2);
      expTimeQ.push_back(expTime());
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL hour_btn_wrap got %h want %h", actTime(), e); end
      compared++;
   endtask

   task automatic test_simultaneous();
      logic [23:0] e;
      setTime(10, 58, 59);
      @(negedge clk);
      drive(0, 1'b1);
      drive(1, 1'b1);
      modelSec();
      expTimeQ.push_back(expTime());
      expTimeQ.push_back(expTime());
      repeat (3) @(posedge clk);
      #1;
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL simul got %h want %h", actTime(), e); end
      compared++;
      repeat (3) @(posedge clk);
      #1;
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL simul_hold got %h want %h", actTime(), e); end
      compared++;
      @(negedge clk);
      drive(0, 1'b0);
      drive(1, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   task automatic test_display();
      dispExp_t e;
      setTime(12, 34, 56);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(3, 1'b1);
         midx = (midx + 1) % 4;
         dispQ.push_back(expDisp());
         repeat (3) @(posedge clk);
         #1;
         e = dispQ.pop_front();
         if (actAnode() !== e.an) begin mismatched++; $display("FAIL disp_anode[%0d] got %b want %b", i, actAnode(), e.an); end
         compared++;
         if (actSeg() !== e.seg) begin mismatched++; $display("FAIL disp_seg[%0d] got %h want %h", i, actSeg(), e.seg); end
         compared++;
         if (actDp() !== e.dp) begin mismatched++; $display("FAIL disp_dp[%0d] got %b want %b", i, actDp(), e.dp); end
         compared++;
         @(negedge clk);
         drive(3, 1'b0);
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_12h_wrap();
      logic [23:0] e;
      setTime(12, 59, 59);
      press(0);
      expTimeQ.push_back(expTime());
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL wrap12 got %h want %h", actTime(), e); end
      compared++;
      setTime(9, 0, 0);
      press(2);
      expTimeQ.push_back(expTime());
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL nine_to_ten got %h want %h", actTime(), e); end
      compared++;
   endtask

   task automatic test_blank();
      dispExp_t e;
      setTime(5, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(3, 1'b1);
         midx = (midx + 1) % 4;
         dispQ.push_back(expDisp());
         repeat (3) @(posedge clk);
         #1;
         e = dispQ.pop_front();
         if (actAnode() !== e.an) begin mismatched++; $display("FAIL blank_anode[%0d] got %b want %b", i, actAnode(), e.an); end
         compared++;
         if (actSeg() !== e.seg) begin mismatched++; $display("FAIL blank_seg[%0d] got %h want %h", i, actSeg(), e.seg); end
         compared++;
         if (actDp() !== e.dp) begin mismatched++; $display("FAIL blank_dp[%0d] got %b want %b", i, actDp(), e.dp); end
         compared++;
         @(negedge clk);
         drive(3, 1'b0);
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [23:0] e;
      @(negedge clk);
      drive(0, 1'b1);
      @(negedge clk);
      setRst(1'b1);
      modelReset();
      expTimeQ.push_back(expTime());
      @(posedge clk);
      #1;
      e = expTimeQ.pop_front();
      if (actTime() !== e) begin mismatched++; $display("FAIL midrst_time got %h want %h", actTime(), e); end
      compared++;
      if (actAnode() !== 4'b1110) begin mismatched++; $display("FAIL midrst_anode got %b want 1110", actAnode()); end
      compared++;
      if (actSeg() !== 7'h40) begin mismatched++; $display("FAIL midrst_seg got %h want 40", actSeg()); end
      compared++;
      @(negedge clk);
      setRst(1'b0);
      drive(0, 1'b0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      segTable[0] = 7'h40; segTable[1] = 7'h79; segTable[2] = 7'h24; segTable[3] = 7'h30;
      segTable[4] = 7'h19; segTable[5] = 7'h12; segTable[6] = 7'h02; segTable[7] = 7'h78;
      segTable[8] = 7'h00; segTable[9] = 7'h10;
      bus24.secondClock = 1'b0; bus24.displayClock = 1'b0; bus24.incMinute = 1'b0; bus24.incHour = 1'b0;
      bus12.secondClock = 1'b0; bus12.displayClock = 1'b0; bus12.incMinute = 1'b0; bus12.incHour = 1'b0;

      twelve = 1'b0;
      test_reset();
      test_seconds();
      test_rollover();
      test_button_no_carry();
      test_simultaneous();
      test_display();

      twelve = 1'b1;
      test_reset();
      test_12h_wrap();
      test_blank();
      test_reset_mid();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
